afifo_rd_packer: RTL and testbench
==================================

Name: afifo_rd_packer

Overview:
- Read-side consumer of the async FIFO. Runs entirely in the read clock domain.
- Pops DSIZE-bit words from the FIFO read port (rd_data / rd_empty / rd_inc) and packs PACK consecutive words LSB-first into one wide output word.
- Presents each packed word on a valid/ready stream to downstream logic. A flush request emits a partial word with a keep mask.

Parameters:
- DSIZE, 8, FIFO word width; must match the FIFO.
- PACK, 4, FIFO words per output word; range 2..16.

Ports:
- rd_clk  input  1  read-domain clock; all logic on rising edge.
- rd_rst  input  1  asynchronous, active-high reset.
- rd_data  input  DSIZE  FIFO head word; valid whenever rd_empty==0 (fall-through).
- rd_empty  input  1  FIFO empty flag.
- rd_inc  output  1  pop strobe to FIFO; the word on rd_data is consumed at this edge.
- flush  input  1  level request to emit the partial word.
- out_data  output  DSIZE*PACK  packed word; slot k at bits [k*DSIZE +: DSIZE].
- out_keep  output  PACK  slot-valid mask for out_data.
- out_valid  output  1  out_data/out_keep valid.
- out_ready  input  1  downstream accept.
- busy  output  1  high when cnt!=0 or out_valid==1.

Behaviour:
- Interface: one clock rd_clk; reset rd_rst is asynchronous and active-high.
- Reset values: cnt=0, acc=0, out_valid=0, out_data=0, out_keep=0, busy=0. rd_inc is combinational and evaluates to 0 under reset.
- Storage:
  - accumulator acc [DSIZE*PACK]
  - count cnt [0..PACK]
  - output register out_data / out_keep / out_valid
- Derived signals:
  - out_free = !out_valid || out_ready
  - xfer = out_free && (cnt==PACK || (flush && cnt!=0))
- Pop rule:
  - rd_inc = !rd_empty && !flush && (cnt<PACK || xfer).
  - Never pop while flush==1.
  - Never pop when empty; rd_inc must be 0 whenever rd_empty==1.
- Pop without xfer: acc slot[cnt] <= rd_data; cnt <= cnt+1.
- xfer:
  - out_data <= acc; out_keep <= (1<<cnt)-1 (all ones when cnt==PACK); out_valid <= 1.
  - Unfilled slots of out_data are 0 (acc is cleared on xfer).
  - Same-cycle pop writes slot 0 of the cleared acc and sets cnt <= 1; otherwise cnt <= 0.
  - Result: full throughput of PACK FIFO words per PACK cycles, with no bubble.
- Handshake:
  - A beat is accepted when out_valid && out_ready.
  - Acceptance with no xfer the same cycle clears out_valid.
  - out_data and out_keep stay stable while out_valid && !out_ready.
- Latency: the word completing cnt==PACK appears on out_valid the next cycle if out_free; otherwise it waits.
- Backpressure: cnt==PACK and !out_free stalls popping (rd_inc=0). The FIFO absorbs the backlog; nothing is dropped.
- Flush:
  - Flush with cnt==0 is a no-op; a zero-keep beat is never emitted.
  - Flush with cnt==PACK behaves as a normal full transfer.
  - Flush held high drains at most one partial word, then idles until deasserted.
- FSM view:
  - ACC (cnt<PACK): advances to FULL on the PACK-th pop without xfer.
  - FULL (cnt==PACK): returns to ACC on xfer.
  - Flush xfer returns to ACC with cnt=0.
- Reset mid-operation: the partial accumulator and any pending output are discarded immediately, asynchronously.

Optional Feature:
- Macro: AFIFO_RD_PACKER_STATS_EN.
- Defined:
  - Adds output port word_cnt [15:0], reset 0.
  - Increments by 1 on each accepted beat (out_valid && out_ready) and saturates at 16'hFFFF.
  - Adds output port partial_cnt [15:0] with the same rules, counting only accepted beats whose out_keep is not all ones.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: rd_rst=1 with rd_empty=0, rd_data=8'hAA.
  - Response: rd_inc=0, out_valid=0, out_data=0, busy=0.
- Pack, DSIZE=8 PACK=4:
  - Stimulus: FIFO holds 11,22,33,44; out_ready=1.
  - Response: rd_inc high 4 cycles; next cycle out_data=32'h44332211, out_keep=4'hF, single beat.
- Streaming:
  - Stimulus: 8 words 01..08 continuously available; out_ready=1.
  - Response: 8 consecutive rd_inc cycles, no bubble; beats 32'h04030201 then 32'h08070605.
- Backpressure:
  - Stimulus: out_ready=0 after the first full word; 6 words available.
  - Response: out_data held at 32'h04030201; cnt reaches 4; rd_inc=0 with 2 words left in the FIFO.
  - On out_ready=1: second word issued, then remaining pops resume.
- Flush:
  - Stimulus: pop A1,B2 then empty, flush=1.
  - Response: out_data=32'h0000B2A1, out_keep=4'h3, rd_inc=0 throughout flush.
  - Response: flush with cnt=0 gives no beat.
- Async reset mid-fill (stats enabled):
  - Stimulus: 3 words popped, then rd_rst pulse between edges.
  - Response: cnt, out_valid, word_cnt cleared immediately.
  - Response: the next 4 pops yield only the new words.

Source files
------------

// File: rtl/afifo_rd_packer.sv
// Read-side packer for the async FIFO, running in the read clock domain.
// Pops DSIZE-bit words from a fall-through FIFO and packs PACK of them
// LSB-first into one wide word on a valid/ready stream. A flush request
// emits the partial word with a slot-valid keep mask.
// Optional statistics counters: define AFIFO_RD_PACKER_STATS_EN.
module afifo_rd_packer #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned PACK  = 4
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic [DSIZE-1:0]        rd_data,
    input  logic                    rd_empty,
    output logic                    rd_inc,
    input  logic                    flush,
    output logic [DSIZE*PACK-1:0]   out_data,
    output logic [PACK-1:0]         out_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
`ifdef AFIFO_RD_PACKER_STATS_EN
    ,
    output logic [15:0]             word_cnt,
    output logic [15:0]             partial_cnt
`endif
);

    localparam int unsigned CW = $clog2(PACK + 1);

    // StFull is exactly cnt == PACK; kept as explicit state for readability.
    typedef enum logic [0:0] {StAcc, StFull} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DSIZE*PACK-1:0]   acc_q, acc_d;
    logic                    out_free;
    logic                    xfer;
    logic                    pop;
    logic [PACK-1:0]         keep_next;

    // Handshake, transfer and pop decisions; slot mask for the word in flight.
    always_comb begin
        out_free = !out_valid || out_ready;
        xfer     = out_free && ((state_q == StFull) || (flush && (cnt_q != '0)));
        // Gate with reset so the FIFO never sees a pop while we are held in reset.
        pop      = !rd_rst && !rd_empty && !flush && ((state_q == StAcc) || xfer);
        for (int k = 0; k < PACK; k++) begin
            keep_next[k] = (CW'(k) < cnt_q);
        end
    end

    // Next-state for accumulator, count and FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (xfer) begin
            // Clear on transfer so unfilled slots of the next word read as zero.
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StAcc;
            if (pop) begin
                acc_d[DSIZE-1:0] = rd_data;
                cnt_d            = CW'(1);
            end
        end else if (pop) begin
            for (int k = 0; k < PACK; k++) begin
                if (cnt_q == CW'(k)) begin
                    acc_d[k*DSIZE +: DSIZE] = rd_data;
                end
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(PACK - 1)) begin
                state_d = StFull;
            end
        end
    end

    // Accumulator, count and FSM state registers.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= StAcc;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Output register: load on transfer, hold while stalled, drop valid on accept.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= acc_q;
            out_keep  <= keep_next;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign rd_inc = pop;
    assign busy   = (cnt_q != '0) || out_valid;

`ifdef AFIFO_RD_PACKER_STATS_EN
    // Saturating counters of accepted beats and of accepted partial beats.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            word_cnt    <= '0;
            partial_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (word_cnt != '1) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if ((out_keep != '1) && (partial_cnt != '1)) begin
                partial_cnt <= partial_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Self-checking bench for afifo_rd_packer: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_afifo_rd_packer;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned PACK  = 4;
    localparam int unsigned OW    = DSIZE * PACK;

    logic             rd_clk = 1'b0;
    logic             rd_rst;
    logic [DSIZE-1:0] rd_data;
    logic             rd_empty;
    logic             rd_inc;
    logic             flush;
    logic [OW-1:0]    out_data;
    logic [PACK-1:0]  out_keep;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
`ifdef AFIFO_RD_PACKER_STATS_EN
    logic [15:0]      word_cnt;
    logic [15:0]      partial_cnt;
`endif

    afifo_rd_packer #(
        .DSIZE (DSIZE),
        .PACK  (PACK)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .rd_data   (rd_data),
        .rd_empty  (rd_empty),
        .rd_inc    (rd_inc),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef AFIFO_RD_PACKER_STATS_EN
        ,
        .word_cnt    (word_cnt),
        .partial_cnt (partial_cnt)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, words collected toward the next beat,
    // and the beat currently presented downstream.
    logic [DSIZE-1:0] fifo[$];
    logic [DSIZE-1:0] pend[$];
    logic             mvalid;
    logic [OW-1:0]    mdata;
    logic [PACK-1:0]  mkeep;
    int               mwords;
    int               mpart;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] pack_pend();
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < pend.size(); k++) begin
            r = r | (OW'(pend[k]) << (k * DSIZE));
        end
        return r;
    endfunction

    task automatic model_reset();
        pend.delete();
        mvalid = 1'b0;
        mdata  = '0;
        mkeep  = '0;
        mwords = 0;
        mpart  = 0;
    endtask

    // One clock cycle: drive inputs, check against the model, clock, update model.
    task automatic cycle(input logic fl, input logic rdy);
        int   n;
        logic ofree, xfer, pop, acc;
        flush     = fl;
        out_ready = rdy;
        rd_empty  = (fifo.size() == 0);
        rd_data   = rd_empty ? DSIZE'($urandom) : fifo[0];
        #1;
        n     = pend.size();
        ofree = !mvalid || rdy;
        xfer  = ofree && ((n == PACK) || (fl && n != 0));
        pop   = !rd_empty && !fl && ((n < PACK) || xfer);
        acc   = mvalid && rdy;
        check("rd_inc", rd_inc, pop);
        check("out_valid", out_valid, mvalid);
        if (mvalid) begin
            check("out_data", out_data, mdata);
            check("out_keep", out_keep, mkeep);
        end
        check("busy", busy, (n != 0) || mvalid);
`ifdef AFIFO_RD_PACKER_STATS_EN
        check("word_cnt", word_cnt, mwords);
        check("partial_cnt", partial_cnt, mpart);
`endif
        @(posedge rd_clk);
        #1;
        if (acc) begin
            mwords++;
            if (mkeep != {PACK{1'b1}}) mpart++;
        end
        if (xfer) begin
            mdata  = pack_pend();
            mkeep  = PACK'((1 << n) - 1);
            mvalid = 1'b1;
            pend.delete();
        end else if (acc) begin
            mvalid = 1'b0;
        end
        if (pop) begin
            pend.push_back(fifo.pop_front());
        end
    endtask

    task automatic run(input int cycles, input logic fl, input logic rdy);
        for (int i = 0; i < cycles; i++) cycle(fl, rdy);
    endtask

    initial begin
        // Reset with a non-empty FIFO presenting AA.
        model_reset();
        rd_rst    = 1'b1;
        rd_empty  = 1'b0;
        rd_data   = 8'hAA;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_rd_inc", rd_inc, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        @(posedge rd_clk);
        #1;
        check("rst_hold_rd_inc", rd_inc, 1'b0);
        rd_rst = 1'b0;

        // Basic pack of four words.
        fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33); fifo.push_back(8'h44);
        run(5, 1'b0, 1'b1);
        check("pack_data", out_data, 32'h44332211);
        check("pack_keep", out_keep, 4'hF);
        check("pack_valid", out_valid, 1'b1);
        run(1, 1'b0, 1'b1);
        check("pack_single", out_valid, 1'b0);

        // Streaming eight words with no bubble.
        for (int i = 1; i <= 8; i++) fifo.push_back(DSIZE'(i));
        run(5, 1'b0, 1'b1);
        check("stream_beat0", out_data, 32'h04030201);
        run(4, 1'b0, 1'b1);
        check("stream_beat1", out_data, 32'h08070605);
        run(2, 1'b0, 1'b1);

        // Backpressure after the first full word.
        for (int i = 1; i <= 10; i++) fifo.push_back(DSIZE'(i));
        run(5, 1'b0, 1'b1);
        check("bp_first", out_data, 32'h04030201);
        run(5, 1'b0, 1'b0);
        check("bp_hold_data", out_data, 32'h04030201);
        check("bp_hold_valid", out_valid, 1'b1);
        run(1, 1'b0, 1'b1);
        check("bp_second", out_data, 32'h08070605);
        run(2, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        check("bp_tail_data", out_data, 32'h00000A09);
        check("bp_tail_keep", out_keep, 4'h3);
        run(2, 1'b0, 1'b1);

        // Flush of a two-word partial, then flush held with nothing pending.
        fifo.push_back(8'hA1); fifo.push_back(8'hB2);
        run(3, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        check("flush_data", out_data, 32'h0000B2A1);
        check("flush_keep", out_keep, 4'h3);
        run(3, 1'b1, 1'b1);
        check("flush_empty_nobeat", out_valid, 1'b0);
        fifo.push_back(8'hC3);
        run(2, 1'b1, 1'b1);
        run(1, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        check("flush_c3", out_data, 32'h000000C3);
        run(2, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a fill.
        fifo.push_back(8'h5A); fifo.push_back(8'h5B); fifo.push_back(8'h5C);
        fifo.push_back(8'h5D);
        run(3, 1'b0, 1'b1);
        #2;
        rd_rst = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_rd_inc", rd_inc, 1'b0);
`ifdef AFIFO_RD_PACKER_STATS_EN
        check("arst_word_cnt", word_cnt, 16'h0);
`endif
        model_reset();
        fifo.delete();
        #1;
        rd_rst = 1'b0;
        fifo.push_back(8'h61); fifo.push_back(8'h62);
        fifo.push_back(8'h63); fifo.push_back(8'h64);
        run(5, 1'b0, 1'b1);
        check("arst_new_word", out_data, 32'h64636261);
        run(2, 1'b0, 1'b1);

        // Random traffic, flush and backpressure.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) != 0 && fifo.size() < 12) fifo.push_back(DSIZE'($urandom));
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
